// File: rtl/wallace_pkg.sv
// wallace_pkg
// Shared constants and types for the 8x8 Wallace-tree multiplier: the
// reduction front end (wallace_reduce_pipe) and the downstream adder.
//   N      operand width (only 8 is supported)
//   ROW_W  partial-product / output row width (2*N)
//   row_t  one ROW_W-wide row
//   pp_row partial-product row generator
package wallace_pkg;

    localparam int N     = 8;
    localparam int ROW_W = 2 * N;

    typedef logic [ROW_W-1:0] row_t;

    // Row i of the partial-product matrix: the multiplicand gated by
    // multiplier bit i and placed at bit weight i.
    function automatic row_t pp_row(input logic [N-1:0] a,
                                    input logic         b_bit,
                                    input int           shift);
        row_t r;
        r = b_bit ? row_t'(a) : '0;
        return r << shift;
    endfunction

endpackage

// File: rtl/wallace_reduce_pipe_csa_row.sv
// csa_row
// One W-wide 3:2 carry-save compressor row, purely combinational.
// Ports:
//   x, y, z  in   three rows of equal weight
//   s        out  bitwise sum x^y^z
//   c        out  majority carries, already shifted up one bit; the carry
//                 out of the top bit is dropped (results are modulo 2^W)
module csa_row
    import wallace_pkg::*;
#(
    parameter int W = ROW_W
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    output logic [W-1:0] s,
    output logic [W-1:0] c
);

    logic [W-1:0] maj;

    assign maj = (x & y) | (x & z) | (y & z);
    assign s   = x ^ y ^ z;
    assign c   = {maj[W-2:0], 1'b0};

endmodule

// File: rtl/wallace_reduce_pipe.sv
// wallace_reduce_pipe
// Pipelined, valid/ready front end of the 8x8 Wallace-tree multiplier.
// Operands are captured (S1), the 8 partial-product rows are reduced to 4
// (S2) and then to a sum/carry pair (S3). (out_s + out_c) mod 2^16 equals
// in_a * in_b; the final carry-propagate add happens downstream.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready is combinational
//                        from out_ready through the stage-advance chain)
//   in_a, in_b           unsigned operands, N bits
//   out_valid/out_ready  row-pair handshake
//   out_s, out_c         sum row and weight-aligned carry row, ROW_W bits
module wallace_reduce_pipe #(
    parameter int N     = 8,
    parameter int ROW_W = 2 * N
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ROW_W-1:0] out_s,
    output logic [ROW_W-1:0] out_c
);

    import wallace_pkg::*;

    // Stage advance: a stage loads when it is empty or its content moves on.
    logic adv1, adv2, adv3;

    // S1: operand capture
    logic         v1_q, v1_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;

    // S2: four carry-save rows
    logic             v2_q, v2_d;
    logic [ROW_W-1:0] r2_q [4];
    logic [ROW_W-1:0] r2_d [4];

    // S3: final sum/carry pair
    logic             v3_q, v3_d;
    logic [ROW_W-1:0] s3_q, s3_d;
    logic [ROW_W-1:0] c3_q, c3_d;

    // Combinational reduction tree
    logic [ROW_W-1:0] pp [N];
    logic [ROW_W-1:0] sa0, ca0, sa1, ca1;
    logic [ROW_W-1:0] sb0, cb0, sb1, cb1;
    logic [ROW_W-1:0] sc, cc, sd, cd;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            pp[i] = pp_row(a_q, b_q[i], i);
        end
    end

    // 8 -> 6: two groups of three, pp[6] and pp[7] pass through.
    csa_row #(.W(ROW_W)) u_csa_a0 (.x(pp[0]), .y(pp[1]), .z(pp[2]), .s(sa0), .c(ca0));
    csa_row #(.W(ROW_W)) u_csa_a1 (.x(pp[3]), .y(pp[4]), .z(pp[5]), .s(sa1), .c(ca1));

    // 6 -> 4
    csa_row #(.W(ROW_W)) u_csa_b0 (.x(sa0), .y(ca0), .z(sa1), .s(sb0), .c(cb0));
    csa_row #(.W(ROW_W)) u_csa_b1 (.x(ca1), .y(pp[6]), .z(pp[7]), .s(sb1), .c(cb1));

    // 4 -> 3 (r2_q[3] passes through), then 3 -> 2
    csa_row #(.W(ROW_W)) u_csa_c (.x(r2_q[0]), .y(r2_q[1]), .z(r2_q[2]), .s(sc), .c(cc));
    csa_row #(.W(ROW_W)) u_csa_d (.x(sc), .y(cc), .z(r2_q[3]), .s(sd), .c(cd));

    assign adv3 = !v3_q || out_ready;
    assign adv2 = !v2_q || adv3;
    assign adv1 = !v1_q || adv2;

    assign in_ready  = adv1;
    assign out_valid = v3_q;
    assign out_s     = s3_q;
    assign out_c     = c3_q;

    // Data registers only load when a valid item arrives, so a stage that
    // drains to empty keeps its last rows rather than toggling on bubbles.
    always_comb begin
        v1_d = v1_q;
        a_d  = a_q;
        b_d  = b_q;
        if (adv1) begin
            v1_d = in_valid;
            if (in_valid) begin
                a_d = in_a;
                b_d = in_b;
            end
        end

        v2_d = v2_q;
        r2_d = r2_q;
        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                r2_d[0] = sb0;
                r2_d[1] = cb0;
                r2_d[2] = sb1;
                r2_d[3] = cb1;
            end
        end

        v3_d = v3_q;
        s3_d = s3_q;
        c3_d = c3_q;
        if (adv3) begin
            v3_d = v2_q;
            if (v2_q) begin
                s3_d = sd;
                c3_d = cd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            a_q  <= '0;
            b_q  <= '0;
            v2_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r2_q[i] <= '0;
            end
            v3_q <= 1'b0;
            s3_q <= '0;
            c3_q <= '0;
        end else begin
            v1_q <= v1_d;
            a_q  <= a_d;
            b_q  <= b_d;
            v2_q <= v2_d;
            for (int i = 0; i < 4; i++) begin
                r2_q[i] <= r2_d[i];
            end
            v3_q <= v3_d;
            s3_q <= s3_d;
            c3_q <= c3_d;
        end
    end

endmodule

// File: tb/tb_wallace_reduce_pipe.sv
// tb_wallace_reduce_pipe
// Self-checking bench for wallace_reduce_pipe. Accepted operand pairs push
// their product onto a scoreboard queue; emitted row pairs pop and compare.
module tb_wallace_reduce_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_s;
    logic [15:0] out_c;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q [$];

    // Snapshot taken at the falling edge before each rising edge.
    logic        acc, emit, rdy, vld;
    logic [15:0] sum, s_snap, c_snap;

    always #5 clk = ~clk;

    wallace_reduce_pipe #(.N(8), .ROW_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .out_c     (out_c)
    );

    // One clock: sample handshakes at the falling edge, push accepted
    // products, then step past the rising edge.
    task automatic cycle();
        @(negedge clk);
        rdy    = in_ready;
        vld    = out_valid;
        acc    = in_valid && in_ready;
        emit   = out_valid && out_ready;
        s_snap = out_s;
        c_snap = out_c;
        sum    = out_s + out_c;
        if (acc) exp_q.push_back(16'(in_a) * 16'(in_b));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = '0;
        in_b      = '0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || out_s !== 16'h0 || out_c !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: out_valid=%b out_s=%h out_c=%h, required 0 0000 0000",
                     out_valid, out_s, out_c);
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_latency();
        logic [15:0] e;
        int emit_at = -1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = 8'hFF;
        in_b      = 8'hFF;
        cycle();
        checks++;
        if (acc !== 1'b1) begin
            errors++;
            $display("FAIL latency_accept: accepted=%b, required 1", acc);
        end
        in_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            if (emit && emit_at < 0) begin
                emit_at = k;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL latency_value: unexpected output sum=%h", sum);
                end else begin
                    e = exp_q.pop_front();
                    if (sum !== e || sum !== 16'hFE01) begin
                        errors++;
                        $display("FAIL latency_value: sum=%h, required %h", sum, e);
                    end
                end
            end
        end
        checks++;
        if (emit_at != 3) begin
            errors++;
            $display("FAIL latency_cycles: output after %0d edges, required 3", emit_at);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  pa [4];
        logic [7:0]  pb [4];
        logic [15:0] want [4];
        logic [15:0] e;
        int idx = 0, n_emit = 0, first = -1, last = -1;
        pa[0] = 8'd3;   pb[0] = 8'd5;   want[0] = 16'd15;
        pa[1] = 8'h00;  pb[1] = 8'hAB;  want[1] = 16'd0;
        pa[2] = 8'h80;  pb[2] = 8'd2;   want[2] = 16'h0100;
        pa[3] = 8'h0F;  pb[3] = 8'h11;  want[3] = 16'h00FF;
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            in_valid = (idx < 4);
            if (idx < 4) begin
                in_a = pa[idx];
                in_b = pb[idx];
            end
            cycle();
            if (acc) idx++;
            if (emit) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_value: unexpected output sum=%h", sum);
                end else begin
                    e = exp_q.pop_front();
                    if (sum !== e || (n_emit < 4 && sum !== want[n_emit])) begin
                        errors++;
                        $display("FAIL b2b_value: item %0d sum=%h, required %h", n_emit, sum, e);
                    end
                end
                if (n_emit == 1 && (s_snap !== 16'h0 || c_snap !== 16'h0)) begin
                    errors++;
                    $display("FAIL b2b_zero_rows: out_s=%h out_c=%h, required 0000 0000", s_snap, c_snap);
                end
                if (first < 0) first = k;
                last = k;
                n_emit++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (n_emit != 4 || first != 3 || last != 6) begin
            errors++;
            $display("FAIL b2b_timing: %0d outputs at cycles %0d..%0d, required 4 at 3..6", n_emit, first, last);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] e, s0, c0;
        int idx = 0, n_acc = 0, n_emit = 0, first = -1, last = -1;
        bit have_snap = 0;
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_valid = (idx < 5);
            in_a = 8'(idx * 29 + 11);
            in_b = 8'(idx * 53 + 7);
            cycle();
            if (acc) begin
                idx++;
                n_acc++;
            end
            if (vld) begin
                if (!have_snap) begin
                    s0 = s_snap;
                    c0 = c_snap;
                    have_snap = 1;
                end else begin
                    checks++;
                    if (s_snap !== s0 || c_snap !== c0) begin
                        errors++;
                        $display("FAIL stall_stable: out_s=%h out_c=%h, required %h %h", s_snap, c_snap, s0, c0);
                    end
                end
            end
        end
        checks++;
        if (n_acc != 3 || rdy !== 1'b0) begin
            errors++;
            $display("FAIL stall_accepts: %0d accepted, in_ready=%b, required 3 and 0", n_acc, rdy);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 20 && n_emit < 5; k++) begin
            in_valid = (idx < 5);
            in_a = 8'(idx * 29 + 11);
            in_b = 8'(idx * 53 + 7);
            cycle();
            if (acc) idx++;
            if (emit) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL drain_value: unexpected output sum=%h", sum);
                end else begin
                    e = exp_q.pop_front();
                    if (sum !== e) begin
                        errors++;
                        $display("FAIL drain_value: item %0d sum=%h, required %h", n_emit, sum, e);
                    end
                end
                if (first < 0) first = k;
                last = k;
                n_emit++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (n_emit != 5 || last - first != 4) begin
            errors++;
            $display("FAIL drain_gapless: %0d outputs over cycles %0d..%0d, required 5 consecutive", n_emit, first, last);
        end
    endtask

    task automatic test_bubble();
        logic [15:0] e;
        int n_emit = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_a = 8'(k * 37 + 5);
            in_b = 8'(k * 91 + 3);
            cycle();
        end
        // Pipeline full; the fourth pair is still waiting.
        out_ready = 1'b1;
        cycle();
        checks++;
        if (acc !== 1'b1 || emit !== 1'b1) begin
            errors++;
            $display("FAIL bubble_swap: accepted=%b emitted=%b, required 1 1", acc, emit);
        end
        if (emit) begin
            checks++;
            e = exp_q.pop_front();
            if (sum !== e) begin
                errors++;
                $display("FAIL bubble_value: sum=%h, required %h", sum, e);
            end
        end
        out_ready = 1'b0;
        in_a = 8'hC3;
        in_b = 8'h5A;
        cycle();
        checks++;
        if (acc !== 1'b0 || emit !== 1'b0 || vld !== 1'b1) begin
            errors++;
            $display("FAIL bubble_refull: accepted=%b emitted=%b out_valid=%b, required 0 0 1", acc, emit, vld);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (emit) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bubble_drain: unexpected output sum=%h", sum);
                end else begin
                    e = exp_q.pop_front();
                    if (sum !== e) begin
                        errors++;
                        $display("FAIL bubble_drain: sum=%h, required %h", sum, e);
                    end
                end
                n_emit++;
            end
        end
        checks++;
        if (n_emit != 3 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bubble_count: %0d drained, %0d left, required 3 and 0", n_emit, exp_q.size());
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] e;
        int emit_at = -1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a = 8'h21; in_b = 8'h03;
        cycle();
        in_a = 8'h44; in_b = 8'h05;
        cycle();
        in_valid = 1'b0;
        cycle();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_valid: out_valid=%b, required 1", out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_s !== 16'h0 || out_c !== 16'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: out_valid=%b out_s=%h out_c=%h in_ready=%b, required 0 0000 0000 1",
                     out_valid, out_s, out_c, in_ready);
        end
        exp_q.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a = 8'd7; in_b = 8'd9;
        cycle();
        in_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            if (emit) begin
                checks++;
                if (emit_at >= 0 || exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL post_reset_value: unexpected output sum=%h", sum);
                end else begin
                    emit_at = k;
                    e = exp_q.pop_front();
                    if (sum !== e || sum !== 16'd63) begin
                        errors++;
                        $display("FAIL post_reset_value: sum=%h, required %h", sum, e);
                    end
                end
            end
        end
        checks++;
        if (emit_at != 3) begin
            errors++;
            $display("FAIL post_reset_latency: output after %0d edges, required 3", emit_at);
        end
    endtask

    task automatic test_exhaustive();
        logic [15:0] e;
        int n_acc = 0, n_emit = 0;
        for (int cyc = 0; cyc < 90000 && n_emit < 65536; cyc++) begin
            in_valid  = (n_acc < 65536);
            in_a      = 8'(n_acc >> 8);
            in_b      = 8'(n_acc);
            out_ready = ($urandom_range(31) != 0);
            cycle();
            if (acc) n_acc++;
            if (emit) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL exhaustive_value: unexpected output sum=%h", sum);
                end else begin
                    e = exp_q.pop_front();
                    if (sum !== e) begin
                        errors++;
                        $display("FAIL exhaustive_value: item %0d sum=%h, required %h", n_emit, sum, e);
                    end
                end
                n_emit++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (n_emit != 65536 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL exhaustive_count: %0d outputs, %0d pending, required 65536 and 0", n_emit, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_backpressure();
        test_bubble();
        test_async_reset();
        test_exhaustive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wallace_reduce_pipe.md
# wallace_reduce_pipe

Pipelined, flow-controlled front end of the 8x8 Wallace-tree multiplier. It accepts operand pairs, generates partial products and reduces them through registered 3:2 carry-save layers to two 16-bit rows. Its output feeds the final carry-lookahead adder stage directly. The rows' modular sum equals the unsigned product.

## Interface
- N, default 8: operand width; only 8 is supported.
- ROW_W, default 2*N: output row width (16).
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block accepts the pair this cycle.
- in_a  in  N  multiplicand, unsigned.
- in_b  in  N  multiplier, unsigned.
- out_valid  out  1  row pair present.
- out_ready  in  1  downstream adder accepts the rows.
- out_s  out  ROW_W  sum row.
- out_c  out  ROW_W  carry row, already shifted to its bit weight.

## Operation
- Transfer occurs on a cycle where valid&ready=1, on either port.
- Pipeline stages:
  - S1: register in_a and in_b, then form 8 partial-product rows pp[i] = (in_b[i] ? in_a : 0) << i, each ROW_W wide.
  - S2: reduce 8 rows to 6, then 6 to 4, using two 3:2 layers; register the 4 rows.
  - S3: reduce 4 rows to 3, then 3 to 2; register out_s and out_c.
- Each 3:2 layer computes s = x^y^z and c = ((x&y)|(x&z)|(y&z)) << 1. Bits shifted past bit 15 are dropped.
- A row left over in a layer passes through to the next layer unchanged.
- Invariant: (out_s + out_c) mod 2^16 == in_a*in_b. The product never exceeds 0xFE01, so the modular sum is exact.
- Each stage k holds a valid bit v_k.
- Stage k loads when it is empty or its content moves forward this cycle:
  - S3 advances when !v3 | out_ready.
  - S2 advances when !v2 | S3 advances.
  - S1 advances when !v1 | S2 advances.
- in_ready = S1 advances. It is combinational from out_ready through the chain; no registered skid.
- A stage that does not advance holds its data and valid bit unchanged.
- The pipeline holds at most 3 items; there is no overflow path.
- Transactions never reorder, drop or duplicate.
- out_valid = v3. out_s and out_c must stay stable while out_valid=1 and out_ready=0.

## Timing
- Reset (rst_n low, asynchronous): v1=v2=v3=0 immediately; all data registers cleared to 0.
  - Outputs during reset: out_valid=0, out_s=out_c=0.
  - in_ready = 1 while reset is deasserted and the pipeline is empty.
- Reset mid-operation discards all in-flight items. The first item accepted after release appears with the normal latency.
- Latency: a pair accepted at edge t appears with out_valid=1 after edge t+2, provided no stall occurs. This is 3 register stages including the input capture.
- Throughput: 1 pair per cycle with out_ready held high.
- Simultaneous accept and emit while full with out_ready=1: all stages shift and in_ready=1.
- Full with out_ready=0: in_ready=0 in the same cycle.
- Operand 0 on either input yields out_s=out_c=0.

## Structure
- Package wallace_pkg holds the constants N=8 and ROW_W=16, plus a row type logic [ROW_W-1:0]. The downstream adder shares this package.
- Sub-module csa_row: one ROW_W-wide 3:2 compressor row. It is purely combinational with inputs x, y, z and outputs s, c (c already shifted). It is instantiated 4 times (2 in S2, 2 in S3).
- Valid/advance logic stays in the top module; no separate FSM beyond the three valid bits.

## Test plan
- Reset then 0xFF*0xFF, out_ready=1: out_valid rises 3 edges after acceptance; (out_s+out_c) mod 2^16 = 0xFE01.
- Back-to-back pairs (3,5), (0,0xAB), (0x80,2), (0x0F,0x11) with out_ready=1: outputs in order, summing to 15, 0, 0x100 and 0xFF on consecutive cycles.
- Backpressure: stream 5 pairs with out_ready=0. in_ready drops after 3 accepts and the first rows stay stable. Raising out_ready drains all 5 in order with no gaps.
- Single-cycle bubble: raise out_ready for one cycle while full. Exactly one item is emitted and one new item is accepted in the same cycle.
- Assert rst_n low asynchronously mid-cycle with 2 items in flight: out_valid falls without a clock edge. After release, 7*9 yields 63 with 3-cycle latency.
- Exhaustive 65536 pairs through the pipe with random out_ready: every sum matches a*b.
